// File: rtl/proc_pkg.sv
// proc_pkg: shared writeback types, default widths and the PC register index
package proc_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_ADDR = 4;
  localparam int DEF_LANES = 4;
  localparam logic [3:0] PC_REG = 4'hF;
  typedef struct packed {
    logic [DEF_ADDR-1:0] addr;
    logic isvector;
    logic vect_esc;
    logic [DEF_LANES*DEF_WIDTH-1:0] data;
  } wb_req_t;
  typedef enum logic {IDLE, DRAIN} wb_state_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: request queue whose pointers carry an extra wrap bit to tell full from empty
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  T     pushData,
  output T     popData,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wrPtr, rdPtr;
  T mem [DEPTH];
  assign popData = mem[rdPtr[AW-1:0]];
  assign empty = wrPtr == rdPtr;
  assign full = (wrPtr[AW-1:0] == rdPtr[AW-1:0]) && (wrPtr[AW] != rdPtr[AW]);
  always_ff @(posedge clk)
    if (push && !full) mem[wrPtr[AW-1:0]] <= pushData;
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push && !full) wrPtr <= wrPtr + 1'b1;
      if (pop && !empty) rdPtr <= rdPtr + 1'b1;
    end
  end
endmodule

// File: rtl/wb_sequencer.sv
// wb_sequencer: queues writeback requests and serialises them onto the regfile write port lane by lane
module wb_sequencer import proc_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ADDR = DEF_ADDR,
  parameter int LANES = DEF_LANES,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR-1:0]          in_addr,
  input  logic                     in_isvector,
  input  logic                     in_vect_esc,
  input  logic [LANES*WIDTH-1:0]   in_data,
  input  logic                     hold,
  output logic                     we3,
  output logic [ADDR-1:0]          wa3,
  output logic [WIDTH-1:0]         wd3,
  output logic                     isvector,
  output logic                     vect_esc,
  output logic [$clog2(LANES)-1:0] lane,
  output logic                     busy,
  output logic                     err_pc
);
  localparam int LW = $clog2(LANES);
  typedef struct packed {
    logic [ADDR-1:0] addr;
    logic isvector;
    logic vect_esc;
    logic [LANES*WIDTH-1:0] data;
  } reqT;
  reqT inReq, head, cur;
  wb_state_t state;
  logic [LW-1:0] laneCnt;
  logic full, empty, pop, last;
  assign inReq = {in_addr, in_isvector, in_vect_esc, in_data};
  assign in_ready = !full;
  assign busy = !empty || state == DRAIN || we3;
  always_comb begin
    last = !cur.isvector || laneCnt == LW'(LANES - 1);
    pop = !hold && !empty && (state == IDLE || last);
  end
  wb_fifo #(.DEPTH(DEPTH), .T(reqT)) fifo (
    .clk(clk), .rst(rst), .push(in_valid), .pop(pop),
    .pushData(inReq), .popData(head), .full(full), .empty(empty)
  );
  // The entry being issued lives in cur; the next one is popped on its last lane so entries run back-to-back
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      laneCnt <= '0;
      cur <= '0;
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
      isvector <= 1'b0;
      vect_esc <= 1'b0;
      lane <= '0;
      err_pc <= 1'b0;
    end else begin
      we3 <= 1'b0;
      isvector <= 1'b0;
      vect_esc <= 1'b0;
      err_pc <= 1'b0;
      if (state == DRAIN && !hold) begin
        if (!cur.isvector && cur.addr == ADDR'(PC_REG)) err_pc <= 1'b1;
        else begin
          we3 <= 1'b1;
          wa3 <= cur.addr;
          wd3 <= (cur.isvector && !cur.vect_esc) ? cur.data[laneCnt*WIDTH +: WIDTH] : cur.data[WIDTH-1:0];
          lane <= laneCnt;
          isvector <= cur.isvector;
          vect_esc <= cur.vect_esc;
        end
        laneCnt <= last ? '0 : laneCnt + 1'b1;
        if (last && empty) state <= IDLE;
      end
      if (pop) begin
        cur <= head;
        state <= DRAIN;
      end
    end
  end
endmodule

// File: tb/tb_wb_sequencer.sv
// tb_wb_sequencer: directed checks of queuing, lane sequencing, stalls, PC discard and reset abort
module tb_wb_sequencer;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_isvector = 1'b0, in_vect_esc = 1'b0, hold = 1'b0;
  logic [3:0] in_addr = '0;
  logic [63:0] in_data = '0;
  logic in_ready, we3, isvector, vect_esc, busy, err_pc;
  logic [3:0] wa3;
  logic [15:0] wd3;
  logic [1:0] lane;
  int nAsserts = 0, nFail = 0, cyc = 0, errCount = 0, errBase = 0;
  typedef struct {
    int cyc;
    logic [3:0] wa;
    logic [15:0] wd;
    logic [1:0] ln;
    logic iv, ve;
  } recT;
  recT logQ[$];
  int addrs[5] = '{1, 2, 5, 7, 9};
  logic [63:0] d;

  wb_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_isvector(in_isvector), .in_vect_esc(in_vect_esc), .in_data(in_data), .hold(hold),
    .we3(we3), .wa3(wa3), .wd3(wd3), .isvector(isvector), .vect_esc(vect_esc),
    .lane(lane), .busy(busy), .err_pc(err_pc)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (we3) logQ.push_back('{cyc, wa3, wd3, lane, isvector, vect_esc});
    if (err_pc) errCount <= errCount + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic iv, input logic ve, input logic [63:0] dat);
    in_addr = a;
    in_isvector = iv;
    in_vect_esc = ve;
    in_data = dat;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chkWrite(input string tag, input logic [3:0] a, input logic [15:0] v,
                          input logic [1:0] l, input logic iv, input logic ve);
    chk({tag, "_we3"}, 32'(we3), 32'd1);
    chk({tag, "_wa3"}, 32'(wa3), 32'(a));
    chk({tag, "_wd3"}, 32'(wd3), 32'(v));
    chk({tag, "_lane"}, 32'(lane), 32'(l));
    chk({tag, "_isvec"}, 32'(isvector), 32'(iv));
    chk({tag, "_vesc"}, 32'(vect_esc), 32'(ve));
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_we3", 32'(we3), 0);
    chk("rst_wa3", 32'(wa3), 0);
    chk("rst_wd3", 32'(wd3), 0);
    chk("rst_isvec", 32'(isvector), 0);
    chk("rst_vesc", 32'(vect_esc), 0);
    chk("rst_lane", 32'(lane), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_errpc", 32'(err_pc), 0);
    chk("rst_ready", 32'(in_ready), 1);

    push(4'd3, 1'b0, 1'b0, 64'd9);
    chk("sc_n0_we3", 32'(we3), 0);
    tick();
    chk("sc_n1_we3", 32'(we3), 0);
    tick();
    chkWrite("sc", 4'd3, 16'd9, 2'd0, 1'b0, 1'b0);
    tick();
    chk("sc_after_we3", 32'(we3), 0);
    chk("sc_after_isvec", 32'(isvector), 0);
    chk("sc_after_busy", 32'(busy), 0);

    push(4'd4, 1'b1, 1'b0, {16'd5, 16'd6, 16'd7, 16'd8});
    tick();
    tick();
    for (int l = 0; l < 4; l++) begin
      chkWrite($sformatf("vec_l%0d", l), 4'd4, 16'(8 - l), 2'(l), 1'b1, 1'b0);
      tick();
    end
    chk("vec_after_we3", 32'(we3), 0);

    push(4'd6, 1'b1, 1'b1, {16'hAAAA, 16'hBBBB, 16'hCCCC, 16'd3});
    tick();
    tick();
    chkWrite("bc_l0", 4'd6, 16'd3, 2'd0, 1'b1, 1'b1);
    tick();
    chkWrite("bc_l1", 4'd6, 16'd3, 2'd1, 1'b1, 1'b1);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bc_hold%0d_we3", i), 32'(we3), 0);
      chk($sformatf("bc_hold%0d_vesc", i), 32'(vect_esc), 0);
    end
    hold = 1'b0;
    tick();
    chkWrite("bc_l2", 4'd6, 16'd3, 2'd2, 1'b1, 1'b1);
    tick();
    chkWrite("bc_l3", 4'd6, 16'd3, 2'd3, 1'b1, 1'b1);
    tick();
    chk("bc_after_we3", 32'(we3), 0);

    logQ.delete();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) d[k*16 +: 16] = 16'(addrs[i] * 16 + k);
      chk($sformatf("full_ready%0d", i), 32'(in_ready), 1);
      push(4'(addrs[i]), 1'b1, 1'b0, d);
    end
    chk("full_ready_low", 32'(in_ready), 0);
    chk("full_busy", 32'(busy), 1);
    chk("full_no_we3", 32'(we3), 0);
    for (int k = 0; k < 4; k++) d[k*16 +: 16] = 16'(addrs[4] * 16 + k);
    in_addr = 4'(addrs[4]);
    in_isvector = 1'b1;
    in_vect_esc = 1'b0;
    in_data = d;
    in_valid = 1'b1;
    tick();
    chk("full_still_low", 32'(in_ready), 0);
    hold = 1'b0;
    for (int i = 0; i < 10 && !in_ready; i++) tick();
    chk("full_ready_back", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 60 && busy; i++) tick();
    chk("full_drained", 32'(busy), 0);
    chk("full_count", 32'(logQ.size()), 20);
    for (int k = 0; k < logQ.size() && k < 20; k++) begin
      chk($sformatf("full_e%0d_wa3", k), 32'(logQ[k].wa), 32'(addrs[k/4]));
      chk($sformatf("full_e%0d_wd3", k), 32'(logQ[k].wd), 32'(addrs[k/4] * 16 + k % 4));
      chk($sformatf("full_e%0d_lane", k), 32'(logQ[k].ln), 32'(k % 4));
      chk($sformatf("full_e%0d_isvec", k), 32'(logQ[k].iv), 1);
      chk($sformatf("full_e%0d_cycle", k), 32'(logQ[k].cyc), 32'(logQ[0].cyc + k));
    end

    logQ.delete();
    errBase = errCount;
    push(4'd15, 1'b0, 1'b0, 64'd77);
    push(4'd2, 1'b0, 1'b0, 64'h55);
    for (int i = 0; i < 20 && busy; i++) tick();
    chk("pc_drained", 32'(busy), 0);
    chk("pc_err_cycles", 32'(errCount - errBase), 1);
    chk("pc_we3_count", 32'(logQ.size()), 1);
    if (logQ.size() > 0) begin
      chk("pc_next_wa3", 32'(logQ[0].wa), 2);
      chk("pc_next_wd3", 32'(logQ[0].wd), 32'h55);
      chk("pc_next_isvec", 32'(logQ[0].iv), 0);
    end

    push(4'd10, 1'b1, 1'b0, {16'd4, 16'd3, 16'd2, 16'd1});
    push(4'd11, 1'b1, 1'b0, {16'd4, 16'd3, 16'd2, 16'd1});
    push(4'd12, 1'b1, 1'b0, {16'd4, 16'd3, 16'd2, 16'd1});
    for (int i = 0; i < 10 && !(we3 && lane == 2'd1); i++) tick();
    chk("abort_at_lane1", 32'(we3 && lane == 2'd1), 1);
    chk("abort_wa3", 32'(wa3), 10);
    rst = 1'b1;
    tick();
    chk("abort_we3", 32'(we3), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ready", 32'(in_ready), 1);
    rst = 1'b0;
    logQ.delete();
    for (int i = 0; i < 10; i++) tick();
    chk("abort_no_writes", 32'(logQ.size()), 0);
    chk("abort_idle_busy", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end
endmodule
